text_glyph_fetch: RTL and testbench

- Parametrised successor to the text-mode character bitmap RAM.
- Holds font bitmaps in an internal dual-port RAM. The system bus reads and writes it on port A; port B serves glyph-scanline fetch requests from the text controller.
- Each fetch computes the glyph byte address, reads two consecutive words, extracts and aligns an arbitrary-width scanline (1..pMaxPix pixels), masks unused pixels and optionally mirrors it.
- Delivers the scanline over a valid/ready handshake. Single clock domain.

---
 rtl/text_glyph_fetch_if.sv | 58 +++++
 rtl/text_glyph_fetch.sv | 232 +++++++++++++++++++++++
 tb/tb_text_glyph_fetch.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_glyph_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : text_glyph_fetch_if
// Purpose  : Bundles the system-bus port and the glyph-fetch handshake of
//            text_glyph_fetch.
//            slave  : seen by the glyph fetch block.
//            master : seen by the bus master / text controller.
// Signals  : cs/we/sel/adr/dat_i -> dat_o/ack_o     (bus, port A)
//            req_i + fetch fields -> req_rdy_o       (fetch request)
//            bmp_o/bmp_vld_o/oor_o <- bmp_rdy_i      (scanline result)
// Revision : 1.0 - initial release
// ============================================================================
interface text_glyph_fetch_if #(
  parameter int pDataWidth = 64,
  parameter int pAddrWidth = 13,
  parameter int pMaxPix    = 64
);
  localparam int c_lane_bits = $clog2(pDataWidth / 8);

  logic                              cs_i;
  logic                              we_i;
  logic [pDataWidth/8-1:0]           sel_i;
  logic [pAddrWidth-1:0]             adr_i;
  logic [pDataWidth-1:0]             dat_i;
  logic [pDataWidth-1:0]             dat_o;
  logic                              ack_o;
  logic                              req_i;
  logic                              req_rdy_o;
  logic [12:0]                       char_code_i;
  logic [5:0]                        scanline_i;
  logic [6:0]                        glyph_w_i;
  logic [5:0]                        glyph_h_i;
  logic [pAddrWidth+c_lane_bits-1:0] font_adr_i;
  logic                              mirror_i;
  logic [pMaxPix-1:0]                bmp_o;
  logic                              bmp_vld_o;
  logic                              bmp_rdy_i;
  logic                              oor_o;

  modport slave (
    input  cs_i, we_i, sel_i, adr_i, dat_i,
    output dat_o, ack_o,
    input  req_i, char_code_i, scanline_i, glyph_w_i, glyph_h_i, font_adr_i, mirror_i,
    output req_rdy_o,
    output bmp_o, bmp_vld_o, oor_o,
    input  bmp_rdy_i
  );

  modport master (
    output cs_i, we_i, sel_i, adr_i, dat_i,
    input  dat_o, ack_o,
    output req_i, char_code_i, scanline_i, glyph_w_i, glyph_h_i, font_adr_i, mirror_i,
    input  req_rdy_o,
    input  bmp_o, bmp_vld_o, oor_o,
    output bmp_rdy_i
  );
endinterface
`default_nettype wire

// File: rtl/text_glyph_fetch.sv
`default_nettype none
// ============================================================================
// Module   : text_glyph_fetch
// Purpose  : Font bitmap RAM with a byte-writable bus port (A) and a glyph
//            scanline fetch engine on port B. A fetch computes the glyph
//            byte address, reads two consecutive words, extracts, masks and
//            optionally mirrors a 1..pMaxPix pixel scanline.
// Ports    : clk_i  - clock, rising edge
//            rst_ni - asynchronous active-low reset
//            bus    - text_glyph_fetch_if.slave (bus port + fetch handshake)
// Revision : 1.0 - initial release
// ============================================================================
module text_glyph_fetch #(
  parameter int    pDataWidth = 64,
  parameter int    pAddrWidth = 13,
  parameter int    pMaxPix    = 64,
  parameter string pFontFile  = "char_bitmaps_12x18.mem"
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  text_glyph_fetch_if.slave bus
);
  localparam int c_bytes     = pDataWidth / 8;
  localparam int c_lane_bits = $clog2(c_bytes);
  localparam int c_badr_w    = pAddrWidth + c_lane_bits;
  localparam int c_depth     = 1 << pAddrWidth;
  localparam logic [7:0] c_max_w = 8'(pMaxPix);

  typedef logic [c_badr_w-1:0]   badr_t;
  typedef logic [pAddrWidth-1:0] wadr_t;
  typedef logic [pMaxPix-1:0]    pix_t;
  typedef logic [pDataWidth-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ADR  = 3'd2,
    S_RD0  = 3'd3,
    S_RD1  = 3'd4,
    S_ALN  = 3'd5,
    S_OUT  = 3'd6
  } state_e;

  // The font image named by pFontFile is bound to the RAM by the
  // implementation flow's memory initialisation; an empty name marks a RAM
  // whose contents are written solely through the bus port.
  if (pFontFile != "") begin : g_font_named
  end

  word_t mem [c_depth];
  word_t rd_q;

  state_e      state_q, state_d;
  logic [12:0] code_q, code_d;
  logic [5:0]  scan_q, scan_d;
  logic [7:0]  w_q, w_d;
  logic [5:0]  h_q, h_d;
  badr_t       base_q, base_d;
  logic        mirror_q, mirror_d;
  logic        hit_oor_q, hit_oor_d;
  logic [12:0] char_words_q, char_words_d;
  logic [11:0] line_off_q, line_off_d;
  badr_t       off_q, off_d;
  word_t       w0_q, w0_d;
  pix_t        bmp_q, bmp_d;
  logic        vld_q, vld_d;
  logic        oor_q, oor_d;
  word_t       dat_q, dat_d;
  logic        ack_q, ack_d;

  logic        req_rdy;
  logic        accept;
  wadr_t       rd_adr;
  logic [5:0]  scan_bytes;
  logic [11:0] char_size;
  pix_t        pix;
  pix_t        masked;
  pix_t        reversed;
  pix_t        aligned;

  // Handshake and port-B address. RD1 fetches the following word; the
  // address wraps naturally at the top of the RAM.
  always_comb begin
    req_rdy = (state_q == S_IDLE) || ((state_q == S_OUT) && bus.bmp_rdy_i);
    accept  = req_rdy && bus.req_i;
    rd_adr  = off_q[c_badr_w-1:c_lane_bits] + wadr_t'(state_q == S_RD1);
  end

  // Geometry and scanline alignment datapath.
  always_comb begin
    scan_bytes = 6'(({1'b0, w_q} + 9'd7) >> 3);
    char_size  = 12'(h_q) * 12'(scan_bytes);
    // {w1,w0} shifted by whole bytes so the scanline's first byte lands at bit 0
    pix        = pix_t'({rd_q, w0_q} >> {off_q[c_lane_bits-1:0], 3'b000});
    masked     = pix & ~({pMaxPix{1'b1}} << w_q);
    reversed   = '0;
    for (int i = 0; i < pMaxPix; i++) begin
      reversed[i] = masked[pMaxPix-1-i];
    end
    // Full-width reversal parks the glyph at the top; shift it back down.
    aligned = mirror_q ? (reversed >> (c_max_w - w_q)) : masked;
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    scan_d       = scan_q;
    w_d          = w_q;
    h_d          = h_q;
    base_d       = base_q;
    mirror_d     = mirror_q;
    hit_oor_d    = hit_oor_q;
    char_words_d = char_words_q;
    line_off_d   = line_off_q;
    off_d        = off_q;
    w0_d         = w0_q;
    bmp_d        = bmp_q;
    vld_d        = vld_q;
    oor_d        = oor_q;

    ack_d = bus.cs_i;
    dat_d = bus.cs_i ? mem[bus.adr_i] : dat_q;

    if (accept) begin
      code_d    = bus.char_code_i;
      scan_d    = bus.scanline_i;
      h_d       = bus.glyph_h_i;
      w_d       = ((bus.glyph_w_i == 7'd0) || ({1'b0, bus.glyph_w_i} > c_max_w))
                  ? c_max_w : {1'b0, bus.glyph_w_i};
      base_d    = bus.font_adr_i & ~badr_t'(c_bytes - 1);
      mirror_d  = bus.mirror_i;
      hit_oor_d = (bus.scanline_i >= bus.glyph_h_i);
      vld_d     = 1'b0;
      oor_d     = 1'b0;
      state_d   = S_MUL;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_MUL: begin
          char_words_d = 13'((13'(char_size) + 13'(c_bytes - 1)) >> c_lane_bits);
          line_off_d   = 12'(scan_q) * 12'(scan_bytes);
          state_d      = S_ADR;
        end
        S_ADR: begin
          off_d   = base_q
                  + badr_t'((32'(code_q) * 32'(char_words_q)) << c_lane_bits)
                  + badr_t'(line_off_q);
          state_d = S_RD0;
        end
        S_RD0: state_d = S_RD1;
        S_RD1: begin
          w0_d    = rd_q;
          state_d = S_ALN;
        end
        S_ALN: begin
          bmp_d   = hit_oor_q ? '0 : aligned;
          oor_d   = hit_oor_q;
          vld_d   = 1'b1;
          state_d = S_OUT;
        end
        S_OUT: begin
          if (bus.bmp_rdy_i) begin
            vld_d   = 1'b0;
            oor_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      code_q       <= '0;
      scan_q       <= '0;
      w_q          <= '0;
      h_q          <= '0;
      base_q       <= '0;
      mirror_q     <= 1'b0;
      hit_oor_q    <= 1'b0;
      char_words_q <= '0;
      line_off_q   <= '0;
      off_q        <= '0;
      w0_q         <= '0;
      bmp_q        <= '0;
      vld_q        <= 1'b0;
      oor_q        <= 1'b0;
      dat_q        <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      scan_q       <= scan_d;
      w_q          <= w_d;
      h_q          <= h_d;
      base_q       <= base_d;
      mirror_q     <= mirror_d;
      hit_oor_q    <= hit_oor_d;
      char_words_q <= char_words_d;
      line_off_q   <= line_off_d;
      off_q        <= off_d;
      w0_q         <= w0_d;
      bmp_q        <= bmp_d;
      vld_q        <= vld_d;
      oor_q        <= oor_d;
      dat_q        <= dat_d;
      ack_q        <= ack_d;
    end
  end

  // RAM array: not reset. Port B samples the array in the same edge as a
  // bus write, so a colliding fetch sees the old word.
  always_ff @(posedge clk_i) begin
    if (bus.cs_i && bus.we_i) begin
      for (int b = 0; b < c_bytes; b++) begin
        if (bus.sel_i[b]) mem[bus.adr_i][b*8 +: 8] <= bus.dat_i[b*8 +: 8];
      end
    end
    rd_q <= mem[rd_adr];
  end

  assign bus.req_rdy_o = req_rdy;
  assign bus.bmp_o     = bmp_q;
  assign bus.bmp_vld_o = vld_q;
  assign bus.oor_o     = oor_q;
  assign bus.dat_o     = dat_q;
  assign bus.ack_o     = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_text_glyph_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_glyph_fetch
// Purpose  : Self-checking bench for text_glyph_fetch: bus port, geometry,
//            alignment, mirroring, out-of-range, back-pressure and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_glyph_fetch;
  localparam int DW = 64;
  localparam int AW = 13;
  localparam int MP = 64;

  typedef struct {
    int          code;
    int          scan;
    int          w;
    int          h;
    int          base;
    bit          mir;
    logic [63:0] bmp;
    bit          oor;
    string       name;
  } vec_t;

  typedef struct {
    logic [63:0] bmp;
    bit          oor;
    int          due;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vecs[9];
  vec_t v5;
  logic vld_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  text_glyph_fetch_if #(.pDataWidth(DW), .pAddrWidth(AW), .pMaxPix(MP)) ifc ();

  text_glyph_fetch #(
    .pDataWidth(DW),
    .pAddrWidth(AW),
    .pMaxPix   (MP),
    .pFontFile ("")
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Scoreboard consumer: every new bmp_vld_o pulse is matched to the oldest
  // accepted request, including its accept-to-valid latency.
  always @(negedge clk) begin
    if (rst_n && ifc.bmp_vld_o && !vld_prev) begin
      if (sb.size() == 0) begin
        timeout("unexpected_vld");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_bmp"}, ifc.bmp_o, e.bmp);
        chk({e.name, "_oor"}, 64'(ifc.oor_o), 64'(e.oor));
        chk({e.name, "_lat"}, 64'(cyc), 64'(e.due));
      end
    end
    vld_prev = ifc.bmp_vld_o;
  end

  task automatic drive_req(input vec_t v);
    ifc.char_code_i = 13'(v.code);
    ifc.scanline_i  = 6'(v.scan);
    ifc.glyph_w_i   = 7'(v.w);
    ifc.glyph_h_i   = 6'(v.h);
    ifc.font_adr_i  = 16'(v.base);
    ifc.mirror_i    = v.mir;
    ifc.req_i       = 1'b1;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.bmp  = v.bmp;
    e.oor  = v.oor;
    e.due  = cyc + 5;
    e.name = v.name;
    sb.push_back(e);
  endtask

  task automatic do_fetch(input vec_t v);
    int t;
    t = 0;
    @(negedge clk);
    drive_req(v);
    while (!ifc.req_rdy_o) begin
      @(negedge clk);
      t++;
      if (t > 50) begin
        timeout({v.name, "_accept"});
        ifc.req_i = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    push_exp(v);
    ifc.req_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      timeout(name);
      sb.delete();
    end
  endtask

  task automatic bus_write(input int adr, input logic [7:0] sel, input logic [63:0] dat);
    @(negedge clk);
    ifc.cs_i  = 1'b1;
    ifc.we_i  = 1'b1;
    ifc.adr_i = 13'(adr);
    ifc.sel_i = sel;
    ifc.dat_i = dat;
    @(negedge clk);
    ifc.cs_i  = 1'b0;
    ifc.we_i  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.cs_i = 0; ifc.we_i = 0; ifc.sel_i = '0; ifc.adr_i = '0; ifc.dat_i = '0;
    ifc.req_i = 0; ifc.char_code_i = '0; ifc.scanline_i = '0; ifc.glyph_w_i = '0;
    ifc.glyph_h_i = '0; ifc.font_adr_i = '0; ifc.mirror_i = 0; ifc.bmp_rdy_i = 1;

    //          code   scan  w    h   base     mir  bmp                      oor name
    vecs[0] = '{'h41,  4,    12,  18, 0,       0,   64'h0F3C,                0, "aligned_12x18"};
    vecs[1] = '{'h41,  4,    12,  18, 0,       1,   64'h03CF,                0, "mirror_12"};
    vecs[2] = '{1,     2,    24,  18, 0,       0,   64'hCCBBAA,              0, "span_24"};
    vecs[3] = '{2,     3,    8,   8,  'h105,   1,   64'h80,                  0, "mirror_8"};
    vecs[4] = '{'h41,  20,   12,  18, 0,       0,   64'h0,                   1, "oor_20"};
    vecs[5] = '{'h41,  18,   12,  18, 0,       1,   64'h0,                   1, "oor_eq_h"};
    vecs[6] = '{3,     1,    0,   2,  0,       0,   64'hBBAA112233445566,    0, "clamp_w0"};
    vecs[7] = '{3,     1,    100, 2,  0,       0,   64'hBBAA112233445566,    0, "clamp_w100"};
    vecs[8] = '{0,     2,    24,  18, 'hFFFF,  0,   64'h332211,              0, "wrap_top"};
    v5      = '{5,     0,    0,   1,  0,       0,   64'hA1A2A3A4_55667788,   0, "word5_after_write"};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dat_o", ifc.dat_o, 64'h0);
    chk("rst_ack_o", 64'(ifc.ack_o), 64'h0);
    chk("rst_bmp_o", ifc.bmp_o, 64'h0);
    chk("rst_bmp_vld_o", 64'(ifc.bmp_vld_o), 64'h0);
    chk("rst_oor_o", 64'(ifc.oor_o), 64'h0);
    chk("rst_req_rdy_o", 64'(ifc.req_rdy_o), 64'h1);
    rst_n = 1'b1;

    // Font preload
    bus_write(326,  8'hFF, 64'hFFFFFFFF_FFFF0F3C);
    bus_write(7,    8'hFF, 64'hBBAA1122_33445566);
    bus_write(8,    8'hFF, 64'h12345678_9ABCDECC);
    bus_write(34,   8'hFF, 64'hFFFFFFFF_01FFFFFF);
    bus_write(8191, 8'hFF, 64'h22115555_55555555);
    bus_write(0,    8'hFF, 64'h44444444_44444433);

    // Bus port: partial byte write and read latency
    bus_write(5, 8'hFF, 64'hA1A2A3A4_A5A6A7A8);
    bus_write(5, 8'h0F, 64'h11223344_55667788);
    @(negedge clk);
    ifc.cs_i  = 1'b1;
    ifc.we_i  = 1'b0;
    ifc.adr_i = 13'd5;
    #1 chk("bus_ack_before", 64'(ifc.ack_o), 64'h0);
    @(posedge clk); #1;
    chk("bus_ack", 64'(ifc.ack_o), 64'h1);
    chk("bus_rd_word5", ifc.dat_o, 64'hA1A2A3A4_55667788);
    @(posedge clk); #1;
    chk("bus_ack_held", 64'(ifc.ack_o), 64'h1);
    @(negedge clk);
    ifc.cs_i = 1'b0;
    @(posedge clk); #1;
    chk("bus_ack_drop", 64'(ifc.ack_o), 64'h0);

    // Table-driven fetches, issued back to back
    for (int i = 0; i < 9; i++) do_fetch(vecs[i]);
    wait_drain("table_drain");

    do_fetch(v5);
    wait_drain("word5_drain");

    // Back-pressure, then a request accepted on the release edge
    ifc.bmp_rdy_i = 1'b0;
    do_fetch(vecs[0]);
    begin
      int t;
      t = 0;
      while (!ifc.bmp_vld_o && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!ifc.bmp_vld_o) begin
        timeout("stall_vld");
        ifc.bmp_rdy_i = 1'b1;
      end else begin
        drive_req(vecs[2]);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_bmp", ifc.bmp_o, 64'h0F3C);
          chk("stall_vld", 64'(ifc.bmp_vld_o), 64'h1);
          chk("stall_req_rdy", 64'(ifc.req_rdy_o), 64'h0);
        end
        ifc.bmp_rdy_i = 1'b1;
        #1 chk("release_req_rdy", 64'(ifc.req_rdy_o), 64'h1);
        @(posedge clk); #1;
        push_exp(vecs[2]);
        ifc.req_i = 1'b0;
        chk("release_vld_drop", 64'(ifc.bmp_vld_o), 64'h0);
      end
    end
    wait_drain("b2b_drain");

    // Reset in the middle of a fetch
    do_fetch(vecs[0]);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", 64'(ifc.bmp_vld_o), 64'h0);
    chk("midrst_req_rdy", 64'(ifc.req_rdy_o), 64'h1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(vecs[2]);
    wait_drain("post_reset_drain");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
